// File: rtl/mmu_arb_pkg.sv
// Shared types for the MMU request arbiter: FSM state encoding and timeout defaults.
package mmu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int WAIT_CNT_W             = 16;

endpackage

// File: rtl/mmu_rr_pick.sv
// Combinational round-robin picker: first set req_valid bit at or above rr_ptr, wrapping.
module mmu_rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_idx,
    output logic                any_valid
);

    logic [ID_WIDTH-1:0] sel;

    // Walk offsets from farthest to nearest so the closest requester to rr_ptr wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sel       = '0;
        any_valid = |req_valid;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            sel = ID_WIDTH'((int'(rr_ptr) + off) % NUM_REQ);
            if (req_valid[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/mmu_req_arbiter.sv
// Round-robin share of one MMU translation port, one translation in flight.
// Optional WAIT watchdog built when MMU_ARB_TIMEOUT_EN is defined.
module mmu_req_arbiter
    import mmu_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 40,
    parameter int ID_WIDTH       = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_vaddr,
    output logic [NUM_REQ-1:0]            req_accept,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic                          resp_hit,
    output logic [ADDR_WIDTH-1:0]         resp_paddr,
    output logic                          resp_err,
    output logic                          mmu_translate_req,
    output logic [ADDR_WIDTH-1:0]         mmu_vaddr,
    input  logic                          mmu_translate_ready,
    input  logic                          mmu_hit,
    input  logic [ADDR_WIDTH-1:0]         mmu_paddr,
    output logic                          busy
);

    arb_state_e state, state_d;

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] vaddr_arr;
    logic [ID_WIDTH-1:0]   rr_ptr, gnt_idx, pick_idx;
    logic [NUM_REQ-1:0]    pick_grant;
    logic                  pick_any;
    logic [ADDR_WIDTH-1:0] vaddr_q, paddr_q;
    logic                  hit_q;
    logic                  capture, timeout;

    assign vaddr_arr = req_vaddr;

    mmu_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_valid (pick_any)
    );

    // Ready counts only while a translation is outstanding; IDLE/RESP pulses are ignored.
    assign capture = ((state == ISSUE) || (state == WAIT)) && mmu_translate_ready;

`ifdef MMU_ARB_TIMEOUT_EN
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  err_q;

    // A ready landing on the timeout cycle takes priority over the abort.
    assign timeout  = (state == WAIT) && !mmu_translate_ready &&
                      (int'(wait_cnt) + 1 >= TIMEOUT_CYCLES);
    assign resp_err = (state == RESP) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            wait_cnt <= (state == WAIT) ? wait_cnt + WAIT_CNT_W'(1) : '0;
            if (capture)      err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
    assign resp_err           = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (pick_any) state_d = ISSUE;
            ISSUE:   state_d = mmu_translate_ready ? RESP : WAIT;
            WAIT:    if (mmu_translate_ready || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            gnt_idx <= '0;
            vaddr_q <= '0;
            hit_q   <= 1'b0;
            paddr_q <= '0;
        end else begin
            if (state == IDLE && pick_any) begin
                gnt_idx <= pick_idx;
                vaddr_q <= vaddr_arr[pick_idx];
                rr_ptr  <= (pick_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : pick_idx + ID_WIDTH'(1);
            end
            if (capture) begin
                hit_q   <= mmu_hit;
                paddr_q <= mmu_paddr;
            end else if (timeout) begin
                hit_q   <= 1'b0;
                paddr_q <= '0;
            end
        end
    end

    assign req_accept        = (state == IDLE && !rst) ? pick_grant : '0;
    assign mmu_translate_req = (state == ISSUE);
    assign mmu_vaddr         = vaddr_q;
    assign resp_valid        = (state == RESP) ? (NUM_REQ'(1) << gnt_idx) : '0;
    assign resp_hit          = (state == RESP) && hit_q;
    assign resp_paddr        = (state == RESP) ? paddr_q : '0;
    assign busy              = (state != IDLE);

endmodule
